subtractor_serial: RTL and testbench
====================================

SUBTRACTOR_SERIAL -- requirements
Module: subtractor_serial

Interface
REQ-001 Parameter SHALL be: width, 32, operand bit width (minimum 2).
REQ-002 Port SHALL be: clk  input  1  rising-edge clock, only clock domain.
REQ-003 Port SHALL be: rst  input  1  synchronous, active-high reset.
REQ-004 Port SHALL be: start  input  1  request; sampled only when ready=1.
REQ-005 Port SHALL be: a  input  width  minuend, captured on accepted start.
REQ-006 Port SHALL be: b  input  width  subtrahend, captured on accepted start.
REQ-007 Port SHALL be: b_in  input  1  borrow-in, captured on accepted start.
REQ-008 Port SHALL be: ready  output  1  high in IDLE and DONE; start accepted.
REQ-009 Port SHALL be: done  output  1  one-cycle pulse; result valid.
REQ-010 Port SHALL be: bo_d  output  width+1  {borrow-out, difference}; bit width is borrow-out, bits width-1:0 are a-b-b_in mod 2^width.

Function
REQ-011 Block SHALL use a three-state FSM: IDLE, RUN, DONE.
REQ-012 IDLE or DONE with start=1 SHALL capture a, b and b_in, clear the bit counter, and enter RUN; without start, DONE SHALL go to IDLE and IDLE SHALL stay in IDLE.
REQ-013 RUN SHALL process one bit per cycle, LSB first, using d=a^b^br and br_next=(~a&b)|(~a&br)|(b&br), with br initialised to b_in.
REQ-014 The bit counter SHALL count 0..width-1; the cycle with counter=width-1 SHALL be the last RUN cycle, then the FSM SHALL enter DONE.
REQ-015 done SHALL be high exactly in the DONE cycle, i.e. width+1 cycles after the accepting edge.
REQ-016 bo_d SHALL update only at the RUN->DONE edge and SHALL hold its value until the next completion; partial results SHALL NOT be visible.
REQ-017 start while in RUN SHALL be ignored with no effect on the captured operands or the counter.
REQ-018 start in the DONE cycle SHALL be accepted (back-to-back); done still pulses for one cycle only.
REQ-019 Changes to a, b or b_in after acceptance SHALL NOT affect the result.
REQ-020 Borrow-out SHALL equal 1 exactly when a < b+b_in as unsigned values.

Reset
REQ-021 rst=1 at a rising edge SHALL force IDLE, counter=0, bo_d=0, done=0 and ready=1, overriding start.
REQ-022 rst asserted in RUN SHALL abandon the operation: no done pulse, and bo_d=0.
REQ-023 rst SHALL take priority over every other event in the same cycle.

Configuration
REQ-024 Macro SUB_SIGNED_OVF_EN SHALL, when defined, add output port ovf (output, 1 bit): the two's-complement overflow of a-b-b_in, i.e. the borrow into the MSB XOR the borrow out of the MSB.
REQ-025 ovf SHALL update and hold on the same rules as bo_d and SHALL reset to 0.
REQ-026 When SUB_SIGNED_OVF_EN is undefined, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-027 a=5, b=3, b_in=0, start for 1 cycle -> done pulse on cycle 33; bo_d={0,0x00000002}.
REQ-028 a=3, b=5, b_in=0 -> bo_d={1,0xFFFFFFFE}; a=0, b=0, b_in=1 -> bo_d={1,0xFFFFFFFF}.
REQ-029 Start with a=9, b=4, then start with a=1, b=1 at cycle 10 (busy) -> second start ignored; bo_d={0,5}, single done pulse.
REQ-030 rst at cycle 15 of an operation -> no done pulse; bo_d=0; ready=1 next cycle; a new start completes normally.
REQ-031 Back-to-back: start held high across the DONE cycle -> two done pulses 33 cycles apart, each with the correct result.
REQ-032 With SUB_SIGNED_OVF_EN: a=0x80000000, b=1 -> ovf=1, bo_d={0,0x7FFFFFFF}; a=5, b=3 -> ovf=0.

Source files
------------

// File: rtl/subtractor_serial.sv
// subtractor_serial: bit-serial a - b - b_in, one bit per cycle, LSB first.
// Latency: width RUN cycles after the accepting edge, then a one-cycle DONE with the result.
// Backpressure: ready is low during RUN; start is only sampled when ready=1, otherwise ignored.
//
// Ports:
//   clk         rising-edge clock (single domain)
//   rst         synchronous active-high reset, highest priority
//   start       request; a, b, b_in are captured when start=1 and ready=1
//   a, b, b_in  minuend, subtrahend, borrow-in
//   ready       high in IDLE and DONE
//   done        one-cycle pulse when bo_d carries a new result
//   bo_d        {borrow-out, difference}; updates only on completion, holds otherwise
//   ovf         (only with SUB_SIGNED_OVF_EN) two's-complement overflow of a-b-b_in,
//               same update/hold/reset rules as bo_d
module subtractor_serial #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             b_in,
  output logic             ready,
  output logic             done,
  output logic [width:0]   bo_d
`ifdef SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (width > 1) ? $clog2(width) : 1;
  localparam logic [CW-1:0] LAST = CW'(width - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Captured operands stay put for the whole operation; the bit counter
  // selects the current bit so no shifting of the operands is needed.
  logic [width-1:0] a_q, a_d;
  logic [width-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Partial difference is kept internal so that bo_d never shows a half-built value.
  logic [width-1:0] diff_q, diff_d;
  logic [width:0]   res_q, res_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

`ifdef SUB_SIGNED_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic a_bit, b_bit, d_bit, br_next;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    res_d   = res_q;
`ifdef SUB_SIGNED_OVF_EN
    ovf_d   = ovf_q;
`endif

    a_bit   = a_q[cnt_q];
    b_bit   = b_q[cnt_q];
    d_bit   = a_bit ^ b_bit ^ br_q;
    br_next = (~a_bit & b_bit) | (~a_bit & br_q) | (b_bit & br_q);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = b_in;
          cnt_d   = '0;
          diff_d  = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        // start is deliberately not looked at here: requests while busy are dropped.
        diff_d[cnt_q] = d_bit;
        br_d          = br_next;
        cnt_d         = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          res_d   = {br_next, diff_d};
`ifdef SUB_SIGNED_OVF_EN
          // br_q is the borrow into the MSB, br_next the borrow out of it.
          ovf_d   = br_q ^ br_next;
`endif
          cnt_d   = '0;
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    ready_d = (state_d != RUN);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      res_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      res_q   <= res_d;
      ready_q <= ready_d;
      done_q  <= done_d;
`ifdef SUB_SIGNED_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign bo_d  = res_q;
`ifdef SUB_SIGNED_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_subtractor_serial.sv
// tb_subtractor_serial: directed vectors for subtractor_serial, scoreboard-checked.
// Stimulus pushes the hand-computed result and its due cycle; a monitor pops on done.
// Cycle numbering: cyc counts rising edges; results are due W+1 cycles after the drive cycle.
module tb_subtractor_serial;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         b_in;
  logic         ready;
  logic         done;
  logic [W:0]   bo_d;
`ifdef SUB_SIGNED_OVF_EN
  logic         ovf;
`endif

  subtractor_serial #(.width(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .ready (ready),
    .done  (done),
    .bo_d  (bo_d)
`ifdef SUB_SIGNED_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W:0] bo;
    logic       ov;
    int         due;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_err  = 0;
  int   n_done = 0;
  int   n_exp  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      n_done++;
      if (q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, expected 0", cyc);
      end else begin
        mon_e = q.pop_front();
        chk("bo_d", 64'(bo_d), 64'(mon_e.bo));
        chk("done_cycle", 64'(cyc), 64'(mon_e.due));
`ifdef SUB_SIGNED_OVF_EN
        chk("ovf", 64'(ovf), 64'(mon_e.ov));
`endif
      end
    end
  end

  task automatic push_exp(input logic [W:0] ebo, input logic eov, input int due);
    exp_t e;
    e.bo  = ebo;
    e.ov  = eov;
    e.due = due;
    q.push_back(e);
    n_exp++;
  endtask

  // Called at a falling edge with the DUT idle; inputs are scrambled after acceptance.
  task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin,
                       input logic [W:0] ebo, input logic eov, input bit push);
    chk("ready_at_issue", 64'(ready), 64'd1);
    a     = va;
    b     = vb;
    b_in  = vbin;
    start = 1'b1;
    if (push) push_exp(ebo, eov, cyc + W + 1);
    @(negedge clk);
    start = 1'b0;
    a     = ~va;
    b     = ~vb ^ 32'h5a5a_5a5a;
    b_in  = ~vbin;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (q.size() != 0 && t < W * 4) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL timeout: %0d results still pending, expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin,
                     input logic [W:0] ebo, input logic eov);
    issue(va, vb, vbin, ebo, eov, 1'b1);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    b_in  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_done",  64'(done),  64'd0);
    chk("rst_bo_d",  64'(bo_d),  64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic value and latency
    run(32'd5, 32'd3, 1'b0, {1'b0, 32'h0000_0002}, 1'b0);

    // Result must hold while the next operation is in flight
    issue(32'd3, 32'd5, 1'b0, {1'b1, 32'hFFFF_FFFE}, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    chk("bo_d_hold",  64'(bo_d),  64'({1'b0, 32'h0000_0002}));
    chk("ready_busy", 64'(ready), 64'd0);
    chk("done_busy",  64'(done),  64'd0);
    wait_idle();

    // Directed vectors, including borrow-in and signed-overflow corners
    run(32'h0000_0000, 32'h0000_0000, 1'b1, {1'b1, 32'hFFFF_FFFF}, 1'b0);
    run(32'h8000_0000, 32'h0000_0001, 1'b0, {1'b0, 32'h7FFF_FFFF}, 1'b1);
    run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, {1'b1, 32'hFFFF_FFFF}, 1'b0);
    run(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, {1'b1, 32'h8000_0000}, 1'b1);
    run(32'h1234_5678, 32'h1234_5678, 1'b0, {1'b0, 32'h0000_0000}, 1'b0);

    // Start while busy is ignored
    issue(32'd9, 32'd4, 1'b0, {1'b0, 32'h0000_0005}, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    chk("ready_before_busy_start", 64'(ready), 64'd0);
    a     = 32'd1;
    b     = 32'd1;
    b_in  = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset in the middle of an operation abandons it
    issue(32'h0000_0100, 32'h0000_0001, 1'b0, '0, 1'b0, 1'b0);
    repeat (13) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_bo_d",  64'(bo_d),  64'd0);
    chk("midrst_done",  64'(done),  64'd0);
    chk("midrst_ready", 64'(ready), 64'd1);
    rst = 1'b0;
    repeat (W + 5) @(negedge clk);
    chk("after_rst_bo_d", 64'(bo_d), 64'd0);
    run(32'd20, 32'd7, 1'b1, {1'b0, 32'h0000_000C}, 1'b0);

    // Back-to-back: start held high across the DONE cycle
    chk("ready_b2b", 64'(ready), 64'd1);
    c     = cyc;
    a     = 32'h0000_0064;
    b     = 32'h0000_0001;
    b_in  = 1'b0;
    start = 1'b1;
    push_exp({1'b0, 32'h0000_0063}, 1'b0, c + W + 1);
    @(negedge clk);
    a     = 32'h0000_0010;
    b     = 32'h0000_0020;
    b_in  = 1'b1;
    push_exp({1'b1, 32'hFFFF_FFEF}, 1'b0, c + 2 * W + 2);
    while (cyc < c + W + 2) @(negedge clk);
    start = 1'b0;
    wait_idle();

    chk("done_count", 64'(n_done), 64'(n_exp));

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
